// File: rtl/demux32_1to5_buffered_pkg.sv
// Shared widths, channel count and select helpers for the 1-to-5 word demux.
// Latency: n/a (definitions only). Backpressure: n/a.
// Select codes above SEL_MAX name no channel and are treated as drops.
package demux32_1to5_buffered_pkg;

    localparam int WIDTH   = 32;
    localparam int NUM_OUT = 5;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 8;

    localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic sel_valid(sel_t sel);
        return sel <= SEL_MAX;
    endfunction

endpackage

// File: rtl/demux32_1to5_buffered_if.sv
// Producer-side and consumer-side signals of the word demux, bundled together.
// Latency: n/a (wiring only). Backpressure: in_ready / out_ready carried here.
// master = surrounding logic (producer + consumers), slave = the demux itself.
interface demux32_1to5_buffered_if;
    import demux32_1to5_buffered_pkg::*;

    word_t                      in_data;
    sel_t                       in_sel;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_OUT*WIDTH-1:0]   out_data;
    logic [NUM_OUT-1:0]         out_valid;
    logic [NUM_OUT-1:0]         out_ready;
    logic                       sel_err;
    cnt_t                       drop_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, drop_cnt
    );
endinterface

// File: rtl/demux32_1to5_buffered_out_slot.sv
// One-entry output register slice for a single demux channel.
// Latency: 1 cycle from fill to valid. Backpressure: holds data while ~ready_i.
// The caller only fills when the slot is empty or draining this same cycle.
module demux32_1to5_buffered_out_slot
    import demux32_1to5_buffered_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  fill_i,
    input  word_t data_i,
    input  logic  ready_i,
    output logic  valid_o,
    output word_t data_o
);

    logic  valid_q, valid_d;
    word_t data_q,  data_d;

    // A fill wins over a drain, so drain+fill keeps valid high with no bubble.
    always_comb begin
        valid_d = fill_i | (valid_q & ~ready_i);
        data_d  = fill_i ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux32_1to5_buffered.sv
// Routes one word per cycle to one of five buffered channels chosen by in_sel.
// Latency: 1 cycle. Backpressure: in_ready drops only when the selected channel is stalled.
// Invalid selects are always accepted, discarded, flagged and counted.
module demux32_1to5_buffered
    import demux32_1to5_buffered_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    demux32_1to5_buffered_if.slave  bus
);

    logic [NUM_OUT-1:0] valid;
    logic [NUM_OUT-1:0] fill;
    logic               in_ready;
    logic               accept;
    logic               drop;
    logic               sel_err_q, sel_err_d;
    cnt_t               drop_cnt_q, drop_cnt_d;

    // Ready is a function of the select and downstream ready only, never in_valid.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                in_ready = ~valid[i] | bus.out_ready[i];
            end
        end
    end

    assign accept = bus.in_valid & in_ready;
    assign drop   = accept & ~sel_valid(bus.in_sel);

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_slot
            assign fill[g] = accept & (bus.in_sel == SEL_W'(g));

            demux32_1to5_buffered_out_slot u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .fill_i  (fill[g]),
                .data_i  (bus.in_data),
                .ready_i (bus.out_ready[g]),
                .valid_o (valid[g]),
                .data_o  (bus.out_data[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_comb begin
        sel_err_d  = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.sel_err   = sel_err_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux32_1to5_buffered.sv
// Directed bench for the 1-to-5 buffered word demux.
// Drives and samples 1 time unit after each rising edge.
module tb_demux32_1to5_buffered;
    import demux32_1to5_buffered_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    demux32_1to5_buffered_if bus ();

    demux32_1to5_buffered dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t slot(input int i);
        return bus.out_data[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        tick();
        tick();
        chk("reset_out_valid", 160'(bus.out_valid), 160'h0);
        chk("reset_out_data",  bus.out_data, 160'h0);
        chk("reset_sel_err",   160'(bus.sel_err), 160'h0);
        chk("reset_drop_cnt",  160'(bus.drop_cnt), 160'h0);
        rst_n = 1'b1;
        tick();

        // Routing to every channel with all consumers ready.
        bus.out_ready = 5'h1F;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_sel  = 3'(i);
            bus.in_data = 32'hA0 + 32'(i);
            #1;
            chk($sformatf("route_in_ready_%0d", i), 160'(bus.in_ready), 160'h1);
            tick();
            chk($sformatf("route_valid_%0d", i), 160'(bus.out_valid), 160'(5'b1 << i));
            chk($sformatf("route_data_%0d", i), 160'(slot(i)), 160'(32'hA0 + 32'(i)));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("route_drained", 160'(bus.out_valid), 160'h0);

        // Backpressure on channel 2.
        bus.out_ready = 5'h1B;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd2;
        bus.in_data   = 32'h11;
        #1;
        chk("bp_first_ready", 160'(bus.in_ready), 160'h1);
        tick();
        chk("bp_first_valid", 160'(bus.out_valid), 160'h04);
        chk("bp_first_data",  160'(slot(2)), 160'h11);
        bus.in_data = 32'h22;
        #1;
        chk("bp_second_not_ready", 160'(bus.in_ready), 160'h0);
        tick();
        chk("bp_hold_data",  160'(slot(2)), 160'h11);
        chk("bp_hold_valid", 160'(bus.out_valid), 160'h04);
        bus.out_ready = 5'h1F;
        #1;
        chk("bp_release_ready", 160'(bus.in_ready), 160'h1);
        tick();
        chk("bp_release_data",  160'(slot(2)), 160'h22);
        chk("bp_release_valid", 160'(bus.out_valid), 160'h04);

        // Channel 2 stalled full while channels 0 and 4 stream.
        bus.out_ready = 5'h1B;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel  = (k % 2 == 1) ? 3'd4 : 3'd0;
            bus.in_data = 32'hC0 + 32'(k);
            #1;
            chk($sformatf("iso_ready_%0d", k), 160'(bus.in_ready), 160'h1);
            tick();
            chk($sformatf("iso_valid_%0d", k), 160'(bus.out_valid),
                (k % 2 == 1) ? 160'h14 : 160'h05);
            chk($sformatf("iso_data_%0d", k),
                160'(slot((k % 2 == 1) ? 4 : 0)), 160'(32'hC0 + 32'(k)));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("iso_after_valid", 160'(bus.out_valid), 160'h04);
        chk("iso_ch2_data",    160'(slot(2)), 160'h22);

        // Drain and refill channel 3 in the same cycle.
        bus.out_ready = 5'h13;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd3;
        bus.in_data   = 32'h30;
        tick();
        chk("df_fill_valid", 160'(bus.out_valid), 160'h0C);
        bus.out_ready = 5'h1B;
        bus.in_data   = 32'h33;
        #1;
        chk("df_ready", 160'(bus.in_ready), 160'h1);
        tick();
        chk("df_valid_kept", 160'(bus.out_valid), 160'h0C);
        chk("df_data_new",   160'(slot(3)), 160'h33);
        bus.in_valid = 1'b0;
        tick();
        chk("df_drained", 160'(bus.out_valid), 160'h04);

        // Invalid selects are accepted, discarded and counted.
        bus.in_valid = 1'b1;
        for (int s = 5; s < 8; s++) begin
            bus.in_sel  = 3'(s);
            bus.in_data = 32'hDEAD0000 + 32'(s);
            #1;
            chk($sformatf("inv_ready_%0d", s), 160'(bus.in_ready), 160'h1);
            tick();
            chk($sformatf("inv_sel_err_%0d", s), 160'(bus.sel_err), 160'h1);
            chk($sformatf("inv_valid_%0d", s), 160'(bus.out_valid), 160'h04);
            chk($sformatf("inv_cnt_%0d", s), 160'(bus.drop_cnt), 160'(s - 4));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("inv_err_pulse_end", 160'(bus.sel_err), 160'h0);
        chk("inv_cnt_hold",      160'(bus.drop_cnt), 160'h3);
        chk("inv_ch2_intact",    160'(slot(2)), 160'h22);

        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd7;
        repeat (252) tick();
        chk("sat_reach_ff", 160'(bus.drop_cnt), 160'hFF);
        repeat (48) tick();
        chk("sat_hold_ff",  160'(bus.drop_cnt), 160'hFF);
        chk("sat_sel_err",  160'(bus.sel_err), 160'h1);
        bus.in_valid = 1'b0;
        tick();
        chk("sat_err_clear", 160'(bus.sel_err), 160'h0);

        // Reset in the middle of traffic with words held.
        bus.out_ready = 5'h00;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd0;
        bus.in_data   = 32'h55;
        tick();
        chk("mid_held_valid", 160'(bus.out_valid), 160'h05);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   160'(bus.out_valid), 160'h0);
        chk("mid_rst_data",    bus.out_data, 160'h0);
        chk("mid_rst_cnt",     160'(bus.drop_cnt), 160'h0);
        chk("mid_rst_sel_err", 160'(bus.sel_err), 160'h0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 5'h1F;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd1;
        bus.in_data   = 32'h77;
        tick();
        chk("post_rst_valid", 160'(bus.out_valid), 160'h02);
        chk("post_rst_data",  160'(slot(1)), 160'h77);
        bus.in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
